// File: rtl/ascon_read_dma.sv
// OBI bus-master read DMA: fetches word-aligned data for a byte-addressed command,
// realigns it to the requested start byte and streams it out as 32-bit words.
package ascon_read_dma_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } mgr_obi_rsp_t;
endpackage

module ascon_read_dma
  import ascon_read_dma_pkg::*;
#(
  parameter int unsigned MAX_OUST   = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  output mgr_obi_req_t mgr_req_o,
  input  mgr_obi_rsp_t mgr_rsp_i,
  input  logic         arvalid,
  output logic         arready,
  input  logic [31:0]  araddr,
  input  logic [31:0]  arlen,
  output logic         wvalid,
  input  logic         wready,
  output logic [31:0]  wdata,
  output logic         wlast,
  output logic         err_o
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUST + 1);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_state_nxt;

  logic [31:2]   r_rd_addr;
  logic [31:0]   r_rd_left, r_out_left;
  logic [1:0]    r_off;
  logic [2:0]    r_tail;
  logic          r_last_in_p;
  logic [OW-1:0] r_oust;
  logic [31:0]   r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_prev;
  logic          r_have_prev;
  logic          r_wvalid, r_wlast, r_err;
  logic [31:0]   r_wdata;

  logic          w_accept, w_req, w_gnt, w_rsp, w_pop, w_emit, w_out_rdy, w_final, w_done;
  logic [30:0]   w_nrd, w_nout;
  logic [2:0]    w_tail;
  logic [31:0]   w_head, w_c, w_word;
  logic [63:0]   w_sh;

  // Word counts for the command: reads span off+len bytes, output spans len bytes.
  assign w_nrd  = 31'(({1'b0, arlen} + {31'd0, araddr[1:0]} + 33'd3) >> 2);
  assign w_nout = 31'(({1'b0, arlen} + 33'd3) >> 2);
  assign w_tail = {1'b0, arlen[1:0] - 2'd1} + 3'd1;

  assign w_accept = arvalid && (r_state == IDLE);
  // Reserve FIFO space for every read in flight so responses never need back-pressure.
  assign w_req = (r_state == BUSY) && (r_rd_left != 32'd0) &&
                 (32'(r_oust) < MAX_OUST) &&
                 (32'(r_cnt) + 32'(r_oust) < FIFO_DEPTH);
  assign w_gnt = w_req && mgr_rsp_i.gnt;
  assign w_rsp = mgr_rsp_i.rvalid && (r_oust != '0);

  always_comb begin
    mgr_req_o      = '0;
    mgr_req_o.req  = w_req;
    mgr_req_o.addr = {r_rd_addr, 2'b00};
    mgr_req_o.be   = 4'hF;
  end

  assign w_out_rdy = !r_wvalid || wready;
  assign w_final   = (r_out_left == 32'd1);
  assign w_done    = (r_out_left == 32'd0) && (r_oust == '0) && w_out_rdy;
  assign w_head    = r_fifo[r_rptr];
  assign w_c       = (w_final && r_last_in_p) ? 32'd0 : w_head;
  assign w_sh      = {w_c, r_prev} >> {r_off, 3'b000};

  always_comb begin
    w_state_nxt = r_state;
    arready     = 1'b0;
    case (r_state)
      IDLE: begin
        arready = 1'b1;
        if (arvalid && arlen != 32'd0) w_state_nxt = BUSY;
      end
      BUSY:    if (w_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_pop  = 1'b0;
    w_emit = 1'b0;
    w_word = w_head;
    if (r_state == BUSY && r_out_left != 32'd0) begin
      if (r_off == 2'd0) begin
        if (w_out_rdy && r_cnt != '0) begin
          w_pop  = 1'b1;
          w_emit = 1'b1;
        end
      end else if (!r_have_prev) begin
        w_pop = (r_cnt != '0);
      end else if (w_out_rdy) begin
        w_word = w_sh[31:0];
        // A tail that sits entirely in P needs no further word from the FIFO.
        if (w_final && r_last_in_p) begin
          w_emit = 1'b1;
        end else if (r_cnt != '0) begin
          w_pop  = 1'b1;
          w_emit = 1'b1;
        end
      end
    end
    for (int i = 0; i < 4; i++)
      if (w_final && (3'(i) >= r_tail)) w_word[8*i +: 8] = 8'h00;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (w_rsp) r_fifo[r_wptr] <= mgr_rsp_i.r.rdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_addr   <= '0;
      r_rd_left   <= '0;
      r_out_left  <= '0;
      r_off       <= '0;
      r_tail      <= '0;
      r_last_in_p <= 1'b0;
      r_oust      <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_wvalid    <= 1'b0;
      r_wlast     <= 1'b0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rd_addr   <= araddr[31:2];
        r_rd_left   <= {1'b0, w_nrd};
        r_out_left  <= {1'b0, w_nout};
        r_off       <= araddr[1:0];
        r_tail      <= w_tail;
        r_last_in_p <= (w_nrd == w_nout);
        r_have_prev <= 1'b0;
        r_err       <= 1'b0;
      end else begin
        if (w_gnt) begin
          r_rd_addr <= r_rd_addr + 30'd1;
          r_rd_left <= r_rd_left - 32'd1;
        end
        if (w_emit) r_out_left <= r_out_left - 32'd1;
        if (w_pop && r_off != 2'd0) begin
          r_prev      <= w_head;
          r_have_prev <= 1'b1;
        end
        if (w_rsp && mgr_rsp_i.r.err) r_err <= 1'b1;
      end

      case ({w_gnt, w_rsp})
        2'b10:   r_oust <= r_oust + OW'(1);
        2'b01:   r_oust <= r_oust - OW'(1);
        default: r_oust <= r_oust;
      endcase

      if (w_rsp) r_wptr <= r_wptr + PW'(1);
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_cnt <= r_cnt + CW'(w_rsp) - CW'(w_pop);

      if (w_emit) begin
        r_wvalid <= 1'b1;
        r_wdata  <= w_word;
        r_wlast  <= w_final;
      end else if (wready) begin
        r_wvalid <= 1'b0;
        r_wlast  <= 1'b0;
      end
    end
  end

  assign wvalid = r_wvalid;
  assign wdata  = r_wdata;
  assign wlast  = r_wlast;
  assign err_o  = r_err;
endmodule

// File: tb/tb_ascon_read_dma.sv
// Directed bench for ascon_read_dma: OBI slave with 1-cycle read latency over a
// byte-pattern memory (byte at address A holds A[7:0]).
module tb_ascon_read_dma;
  import ascon_read_dma_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mgr_obi_req_t mreq;
  mgr_obi_rsp_t mrsp;
  logic        arvalid = 1'b0, arready, wvalid, wready = 1'b1, wlast, err_o;
  logic [31:0] araddr = '0, arlen = '0, wdata;

  int n_checks = 0, n_fail = 0;
  logic [31:0] q_addr[$];
  logic [32:0] q_out[$];
  int model_oust = 0, max_oust = 0, n_unstable = 0;
  bit any_req = 1'b0, any_wvalid = 1'b0;
  int rsp_idx = 0, err_at = -1;

  ascon_read_dma #(.MAX_OUST(2), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .mgr_req_o(mreq), .mgr_rsp_i(mrsp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast), .err_o(err_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // Slave + monitor: observe at negedge, drive responses just after posedge.
  initial begin
    logic pend, hold, h_last;
    logic [31:0] pend_addr, h_data;
    hold = 1'b0; h_last = 1'b0; h_data = '0; pend = 1'b0; pend_addr = '0;
    mrsp = '0;
    mrsp.gnt = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_oust = 0;
        hold = 1'b0;
      end else begin
        if (mrsp.rvalid && model_oust > 0) model_oust--;
        if (mreq.req && mrsp.gnt) begin
          q_addr.push_back(mreq.addr);
          model_oust++;
        end
        if (model_oust > max_oust) max_oust = model_oust;
        if (mreq.req) any_req = 1'b1;
        if (wvalid) any_wvalid = 1'b1;
        if (wvalid && wready) q_out.push_back({wlast, wdata});
        if (hold && (wvalid !== 1'b1 || wdata !== h_data || wlast !== h_last)) n_unstable++;
        hold = wvalid && !wready;
        h_data = wdata;
        h_last = wlast;
      end
      pend = mreq.req && mrsp.gnt;
      pend_addr = mreq.addr;
      @(posedge clk);
      #1;
      mrsp.rvalid  = pend;
      mrsp.r.rdata = pend ? mem_word(pend_addr) : 32'd0;
      mrsp.r.err   = pend && (rsp_idx == err_at);
      if (pend) rsp_idx++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_cmd(input logic [31:0] a, input logic [31:0] l);
    q_addr.delete();
    q_out.delete();
    any_req = 1'b0; any_wvalid = 1'b0; max_oust = 0; n_unstable = 0;
    arvalid = 1'b1; araddr = a; arlen = l;
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, input string nm);
    int i;
    i = 0;
    while (i < budget && !(q_out.size() >= n && arready === 1'b1)) begin
      @(posedge clk); #1;
      i++;
    end
    n_checks++;
    if (i >= budget) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d words, need %0d", nm, q_out.size(), n);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_checks += 6;
    if (arready !== 1'b1)   begin n_fail++; $display("FAIL rst arready got %b want 1", arready); end
    if (mreq.req !== 1'b0)  begin n_fail++; $display("FAIL rst req got %b want 0", mreq.req); end
    if (wvalid !== 1'b0)    begin n_fail++; $display("FAIL rst wvalid got %b want 0", wvalid); end
    if (wlast !== 1'b0)     begin n_fail++; $display("FAIL rst wlast got %b want 0", wlast); end
    if (err_o !== 1'b0)     begin n_fail++; $display("FAIL rst err_o got %b want 0", err_o); end
    if (wdata !== 32'd0)    begin n_fail++; $display("FAIL rst wdata got %h want 0", wdata); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_aligned();
    logic [31:0] ea[2];
    logic [32:0] ew[2];
    ea = '{32'h1000, 32'h1004};
    ew = '{{1'b0, 32'h03020100}, {1'b1, 32'h07060504}};
    start_cmd(32'h1000, 32'd8);
    wait_done(2, 100, "aligned");
    n_checks += 3;
    if (q_addr.size() != 2) begin n_fail++; $display("FAIL aligned nreads got %0d want 2", q_addr.size()); end
    if (q_out.size() != 2)  begin n_fail++; $display("FAIL aligned nwords got %0d want 2", q_out.size()); end
    if (arready !== 1'b1)   begin n_fail++; $display("FAIL aligned arready got %b want 1", arready); end
    for (int k = 0; k < 2; k++) begin
      n_checks += 2;
      if (k >= q_addr.size() || q_addr[k] !== ea[k]) begin
        n_fail++; $display("FAIL aligned addr[%0d] got %h want %h", k, (k < q_addr.size()) ? q_addr[k] : 32'hx, ea[k]);
      end
      if (k >= q_out.size() || q_out[k] !== ew[k]) begin
        n_fail++; $display("FAIL aligned word[%0d] got %h want %h", k, (k < q_out.size()) ? q_out[k] : 33'hx, ew[k]);
      end
    end
  endtask

  task automatic test_unaligned();
    logic [31:0] ea[3];
    logic [32:0] ew[2];
    ea = '{32'h1000, 32'h1004, 32'h1008};
    ew = '{{1'b0, 32'h04030201}, {1'b1, 32'h08070605}};
    start_cmd(32'h1001, 32'd8);
    wait_done(2, 100, "unaligned");
    n_checks += 2;
    if (q_addr.size() != 3) begin n_fail++; $display("FAIL unaligned nreads got %0d want 3", q_addr.size()); end
    if (q_out.size() != 2)  begin n_fail++; $display("FAIL unaligned nwords got %0d want 2", q_out.size()); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (k >= q_addr.size() || q_addr[k] !== ea[k]) begin
        n_fail++; $display("FAIL unaligned addr[%0d] got %h want %h", k, (k < q_addr.size()) ? q_addr[k] : 32'hx, ea[k]);
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (k >= q_out.size() || q_out[k] !== ew[k]) begin
        n_fail++; $display("FAIL unaligned word[%0d] got %h want %h", k, (k < q_out.size()) ? q_out[k] : 33'hx, ew[k]);
      end
    end
  endtask

  task automatic test_short_tail();
    start_cmd(32'h1002, 32'd2);
    wait_done(1, 100, "short");
    n_checks += 4;
    if (q_addr.size() != 1) begin n_fail++; $display("FAIL short nreads got %0d want 1", q_addr.size()); end
    if (q_addr.size() < 1 || q_addr[0] !== 32'h1000) begin n_fail++; $display("FAIL short addr got %h want 1000", (q_addr.size() > 0) ? q_addr[0] : 32'hx); end
    if (q_out.size() != 1)  begin n_fail++; $display("FAIL short nwords got %0d want 1", q_out.size()); end
    if (q_out.size() < 1 || q_out[0] !== {1'b1, 32'h00000302}) begin
      n_fail++; $display("FAIL short word got %h want 100000302", (q_out.size() > 0) ? q_out[0] : 33'hx);
    end
  endtask

  task automatic test_odd_len();
    logic [31:0] ea[2];
    logic [32:0] ew[2];
    ea = '{32'h1000, 32'h1004};
    ew = '{{1'b0, 32'h06050403}, {1'b1, 32'h00000007}};
    start_cmd(32'h1003, 32'd5);
    wait_done(2, 100, "odd");
    n_checks += 2;
    if (q_addr.size() != 2) begin n_fail++; $display("FAIL odd nreads got %0d want 2", q_addr.size()); end
    if (q_out.size() != 2)  begin n_fail++; $display("FAIL odd nwords got %0d want 2", q_out.size()); end
    for (int k = 0; k < 2; k++) begin
      n_checks += 2;
      if (k >= q_addr.size() || q_addr[k] !== ea[k]) begin
        n_fail++; $display("FAIL odd addr[%0d] got %h want %h", k, (k < q_addr.size()) ? q_addr[k] : 32'hx, ea[k]);
      end
      if (k >= q_out.size() || q_out[k] !== ew[k]) begin
        n_fail++; $display("FAIL odd word[%0d] got %h want %h", k, (k < q_out.size()) ? q_out[k] : 33'hx, ew[k]);
      end
    end
  endtask

  task automatic test_throttle();
    logic [32:0] ew;
    wready = 1'b0;
    start_cmd(32'h2000, 32'd64);
    repeat (19) begin @(posedge clk); #1; end
    // Output register plus a full 4-word FIFO bound the reads issued while stalled.
    n_checks += 2;
    if (q_addr.size() != 5) begin n_fail++; $display("FAIL throttle stalled reads got %0d want 5", q_addr.size()); end
    if (q_out.size() != 0)  begin n_fail++; $display("FAIL throttle stalled words got %0d want 0", q_out.size()); end
    wready = 1'b1;
    wait_done(16, 300, "throttle");
    n_checks += 4;
    if (q_addr.size() != 16) begin n_fail++; $display("FAIL throttle nreads got %0d want 16", q_addr.size()); end
    if (q_out.size() != 16)  begin n_fail++; $display("FAIL throttle nwords got %0d want 16", q_out.size()); end
    if (max_oust > 2)        begin n_fail++; $display("FAIL throttle max_oust got %0d want <=2", max_oust); end
    if (n_unstable != 0)     begin n_fail++; $display("FAIL throttle unstable_hold got %0d want 0", n_unstable); end
    for (int k = 0; k < 16; k++) begin
      ew = {(k == 15), mem_word(32'h2000 + 32'(4 * k))};
      n_checks += 2;
      if (k >= q_addr.size() || q_addr[k] !== 32'h2000 + 32'(4 * k)) begin
        n_fail++; $display("FAIL throttle addr[%0d] got %h want %h", k, (k < q_addr.size()) ? q_addr[k] : 32'hx, 32'h2000 + 32'(4 * k));
      end
      if (k >= q_out.size() || q_out[k] !== ew) begin
        n_fail++; $display("FAIL throttle word[%0d] got %h want %h", k, (k < q_out.size()) ? q_out[k] : 33'hx, ew);
      end
    end
  endtask

  task automatic test_err_zero();
    logic [32:0] ew[3];
    ew = '{{1'b0, 32'h03020100}, {1'b0, 32'h07060504}, {1'b1, 32'h0B0A0908}};
    err_at = rsp_idx + 1;
    start_cmd(32'h1000, 32'd12);
    wait_done(3, 100, "err");
    err_at = -1;
    n_checks += 2;
    if (err_o !== 1'b1)     begin n_fail++; $display("FAIL err err_o got %b want 1", err_o); end
    if (q_out.size() != 3)  begin n_fail++; $display("FAIL err nwords got %0d want 3", q_out.size()); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (k >= q_out.size() || q_out[k] !== ew[k]) begin
        n_fail++; $display("FAIL err word[%0d] got %h want %h", k, (k < q_out.size()) ? q_out[k] : 33'hx, ew[k]);
      end
    end
    start_cmd(32'h1000, 32'd0);
    repeat (5) begin @(posedge clk); #1; end
    n_checks += 5;
    if (any_req !== 1'b0)    begin n_fail++; $display("FAIL zero req_seen got %b want 0", any_req); end
    if (any_wvalid !== 1'b0) begin n_fail++; $display("FAIL zero wvalid_seen got %b want 0", any_wvalid); end
    if (q_addr.size() != 0)  begin n_fail++; $display("FAIL zero nreads got %0d want 0", q_addr.size()); end
    if (err_o !== 1'b0)      begin n_fail++; $display("FAIL zero err_o got %b want 0", err_o); end
    if (arready !== 1'b1)    begin n_fail++; $display("FAIL zero arready got %b want 1", arready); end
  endtask

  task automatic test_reset_mid();
    logic [32:0] ew[2];
    ew = '{{1'b0, 32'h04030201}, {1'b1, 32'h08070605}};
    start_cmd(32'h2000, 32'd64);
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks += 4;
    if (arready !== 1'b1)  begin n_fail++; $display("FAIL midrst arready got %b want 1", arready); end
    if (mreq.req !== 1'b0) begin n_fail++; $display("FAIL midrst req got %b want 0", mreq.req); end
    if (wvalid !== 1'b0)   begin n_fail++; $display("FAIL midrst wvalid got %b want 0", wvalid); end
    if (wlast !== 1'b0)    begin n_fail++; $display("FAIL midrst wlast got %b want 0", wlast); end
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    start_cmd(32'h1001, 32'd8);
    wait_done(2, 100, "midrst_recover");
    n_checks += 2;
    if (q_addr.size() != 3) begin n_fail++; $display("FAIL midrst nreads got %0d want 3", q_addr.size()); end
    if (q_out.size() != 2)  begin n_fail++; $display("FAIL midrst nwords got %0d want 2", q_out.size()); end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (k >= q_out.size() || q_out[k] !== ew[k]) begin
        n_fail++; $display("FAIL midrst word[%0d] got %h want %h", k, (k < q_out.size()) ? q_out[k] : 33'hx, ew[k]);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_aligned();
    test_unaligned();
    test_short_tail();
    test_odd_len();
    test_throttle();
    test_err_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
